// File: rtl/div_rem_iterative.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow resolve in one cycle.
module div_rem_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src1_value,
  input  logic [DATA_WIDTH-1:0] src2_value,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | shift-subtract iterations, cnt counts down to 1
  // FIX   | select quotient/remainder and apply sign
  // DONE  | one-cycle result strobe, accepts back-to-back start
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int RW = DATA_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]  ITER    = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]  cnt;
  logic [RW-1:0]         rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] div_abs;
  logic [1:0]            op_q;
  logic                  neg_q;
  logic                  neg_r;

  logic                  accept;
  logic                  is_signed;
  logic                  div_zero;
  logic                  overflow;
  logic                  special;
  logic [DATA_WIDTH-1:0] special_res;
  logic [DATA_WIDTH-1:0] src1_abs;
  logic [DATA_WIDTH-1:0] src2_abs;
  logic [RW:0]           shifted;
  logic                  trial_ge;
  logic [RW-1:0]         rem_nxt;
  logic [DATA_WIDTH-1:0] fix_sel;
  logic [DATA_WIDTH-1:0] fix_res;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign is_signed = ~op[0];
  assign div_zero  = (src2_value == '0);
  assign overflow  = is_signed && (src1_value == MIN_NEG) && (src2_value == '1);
  assign special   = div_zero || overflow;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? src1_value : '1;
    else          special_res = op[1] ? '0 : src1_value;
  end

  assign src1_abs = (is_signed && src1_value[DATA_WIDTH-1]) ? -src1_value : src1_value;
  assign src2_abs = (is_signed && src2_value[DATA_WIDTH-1]) ? -src2_value : src2_value;

  // Partial remainder never exceeds the divisor, so the extra top bit is a guard only
  assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial_ge = (shifted >= {2'b00, div_abs});
  assign rem_nxt  = RW'(trial_ge ? (shifted - {2'b00, div_abs}) : shifted);

  assign fix_sel = op_q[1] ? rem_q[DATA_WIDTH-1:0] : quo_q;
  assign fix_res = (op_q[1] ? neg_r : neg_q) ? -fix_sel : fix_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_ONE) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = special ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_abs <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= op;
      rem_q   <= '0;
      quo_q   <= src1_abs;
      div_abs <= src2_abs;
      neg_q   <= is_signed && (src1_value[DATA_WIDTH-1] ^ src2_value[DATA_WIDTH-1]);
      neg_r   <= is_signed && src1_value[DATA_WIDTH-1];
      cnt     <= special ? '0 : ITER;
      if (special) result <= special_res;
    end else if (state == CALC) begin
      rem_q <= rem_nxt;
      quo_q <= {quo_q[DATA_WIDTH-2:0], trial_ge};
      cnt   <= cnt - CNT_ONE;
    end else if (state == FIX) begin
      result <= fix_res;
    end
  end

endmodule
